approx_add_pipe: RTL and testbench

APPROX_ADD_PIPE -- requirements
Module: approx_add_pipe

---
 rtl/approx_add_pipe.sv | 107 ++++++++++
 tb/tb_approx_add_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_add_pipe.sv
// Two-stage pipelined signed adder with a per-transaction speculative-carry approximate mode.
// Keeps running statistics on the error of approximate results.
`timescale 1ns/1ps
module approx_add_pipe #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned APPROX_LSB = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    input  logic             stat_clr,
    output logic [15:0]      err_cnt,
    output logic [WIDTH:0]   err_max
);

    localparam int unsigned SW = WIDTH + 1;
    localparam int unsigned HW = WIDTH + 1 - APPROX_LSB;
    localparam int unsigned DW = WIDTH + 2;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_mode;

    logic             adv2;
    logic             adv1;
    logic             load2;

    logic [SW-1:0]    exact;
    logic [HW-1:0]    approx_hi;
    logic [SW-1:0]    approx;
    logic [DW-1:0]    diff;
    logic [SW-1:0]    err;

    // Handshake: in_ready follows the stage-1 advance condition combinationally.
    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign load2    = adv2 && s1_valid;
    assign in_ready = adv1;

    // Both results and the absolute error, computed from the stage-1 registers.
    always_comb begin
        exact     = {s1_a[WIDTH-1], s1_a} + {s1_b[WIDTH-1], s1_b};
        approx_hi = {s1_a[WIDTH-1], s1_a[WIDTH-1:APPROX_LSB]}
                  + {s1_b[WIDTH-1], s1_b[WIDTH-1:APPROX_LSB]}
                  + HW'(s1_a[APPROX_LSB-1]);
        approx    = {approx_hi, {APPROX_LSB{1'b0}}};
        diff      = {exact[SW-1], exact} - {approx[SW-1], approx};
        err       = diff[DW-1] ? SW'(-diff) : SW'(diff);
    end

    // Stage 1: operand capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mode  <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a    <= a;
                s1_b    <= b;
                s1_mode <= mode;
            end
        end
    end

    // Stage 2: result register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum <= s1_mode ? approx : exact;
            end
        end
    end

    // Error statistics; a clear overrides a coincident update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            err_max <= '0;
        end else if (stat_clr) begin
            err_cnt <= '0;
            err_max <= '0;
        end else if (load2 && s1_mode) begin
            if ((err != '0) && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
            if (err > err_max) begin
                err_max <= err;
            end
        end
    end

endmodule

// File: tb/tb_approx_add_pipe.sv
// Scoreboard bench for approx_add_pipe (WIDTH=16, APPROX_LSB=3).
`timescale 1ns/1ps
module tb_approx_add_pipe;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned K     = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
    logic             stat_clr;
    logic [15:0]      err_cnt;
    logic [WIDTH:0]   err_max;

    approx_add_pipe #(.WIDTH(WIDTH), .APPROX_LSB(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .stat_clr  (stat_clr),
        .err_cnt   (err_cnt),
        .err_max   (err_max)
    );

    int             n_checks = 0;
    int             n_fail   = 0;
    int             n_out    = 0;
    logic [WIDTH:0] sb_q[$];
    logic           prev_stall;
    logic [WIDTH:0] prev_sum;
    logic           in_fire;
    logic [15:0]    m_cnt;
    logic [WIDTH:0] m_max;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model using integer arithmetic.
    task automatic model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic m,
                         output logic [WIDTH:0] res, output int err);
        int sa, sb, ex, hi, ap, d;
        sa  = int'($signed(x));
        sb  = int'($signed(y));
        ex  = sa + sb;
        hi  = (sa >>> K) + (sb >>> K) + int'(x[K-1]);
        ap  = hi * (1 << K);
        d   = ex - ap;
        err = (d < 0) ? -d : d;
        res = m ? 17'(ap) : 17'(ex);
    endtask

    // One clock: drive at negedge, sample 1ns later, update scoreboard for the coming edge.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic im, input logic ordy, input logic clr);
        logic [WIDTH:0] r;
        logic [WIDTH:0] exp_s;
        int             e;
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        mode      = im;
        out_ready = ordy;
        stat_clr  = clr;
        #1;
        check("in_ready", in_ready, (sb_q.size() == 2 && !ordy) ? 0 : 1);
        if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_sum", sum, prev_sum);
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                exp_s = sb_q.pop_front();
                check("sum", sum, exp_s);
                n_out++;
            end
        end
        in_fire = iv && in_ready;
        if (in_fire) begin
            model(ia, ib, im, r, e);
            sb_q.push_back(r);
            if (im) begin
                if (e != 0 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (17'(e) > m_max) m_max = 17'(e);
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_sum   = sum;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        end
        check("drain_timeout", sb_q.size(), 0);
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_cnt"}, err_cnt, m_cnt);
        check({tag, "_max"}, err_max, m_max);
    endtask

    initial begin
        logic [WIDTH-1:0] ra[8];
        logic [WIDTH-1:0] rb[8];
        logic             rm[8];
        int               idx;
        int               j;
        int               n0;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        mode       = 1'b0;
        out_ready  = 1'b1;
        stat_clr   = 1'b0;
        m_cnt      = '0;
        m_max      = '0;
        prev_stall = 1'b0;
        prev_sum   = '0;
        in_fire    = 1'b0;

        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_err_max", err_max, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

        // Latency and first approximate result.
        cycle(1'b1, 16'h0007, 16'h0007, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("lat_not_yet", out_valid, 0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("lat_two", out_valid, 1);
        check("sum_7_7_approx", sum, 17'h00008);
        drain();
        check("err_cnt_one", err_cnt, 1);
        check("err_max_six", err_max, 6);

        // Directed corner pairs, back to back.
        cycle(1'b1, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0);
        drain();
        check("err_cnt_two", err_cnt, 2);
        check_stats("directed");

        // Random stream of 8 pairs under random backpressure.
        for (int i = 0; i < 8; i++) begin
            ra[i] = 16'($urandom);
            rb[i] = 16'($urandom);
            rm[i] = 1'($urandom_range(0, 1));
        end
        n0  = n_out;
        idx = 0;
        for (int c = 0; c < 300 && (idx < 8 || sb_q.size() > 0); c++) begin
            j = (idx < 8) ? idx : 7;
            cycle(idx < 8, ra[j], rb[j], rm[j], 1'($urandom_range(0, 1)), 1'b0);
            if (in_fire) idx++;
        end
        check("stream_count", n_out - n0, 8);
        check_stats("stream");

        // Saturation of the error counter.
        for (int i = 0; i < 65536; i++) begin
            cycle(1'b1, 16'h0007, 16'h0007, 1'b1, 1'b1, 1'b0);
        end
        drain();
        check("sat_cnt", err_cnt, 16'hFFFF);
        check_stats("sat");

        // Clear coincident with an erroneous stage-2 load.
        cycle(1'b1, 16'h0007, 16'h0007, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        m_cnt = '0;
        m_max = '0;
        drain();
        check("clr_cnt", err_cnt, 0);
        check("clr_max", err_max, 0);

        // Reset with both stages full.
        cycle(1'b1, 16'h0007, 16'h0007, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full_before_rst", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_err_cnt", err_cnt, 0);
        check("midrst_err_max", err_max, 0);
        sb_q.delete();
        m_cnt      = '0;
        m_max      = '0;
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
            check("flush_none", out_valid, 0);
        end
        cycle(1'b1, 16'h0003, 16'hFFFC, 1'b0, 1'b1, 1'b0);
        drain();
        check_stats("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
